// File: rtl/line_mem_arbiter_pkg.sv
// line_mem_arbiter_pkg: shared encodings and default widths for the linear-memory arbiter.
package line_mem_arbiter_pkg;
    localparam int bram_in_width = 32;
    localparam int log2_bram_depth_in = 10;
    typedef enum logic {S_IDLE, S_HBURST} state_t;
    typedef enum logic {OWN_CORE, OWN_HOST} owner_t;
endpackage

// File: rtl/line_mem_rd_router.sv
// line_mem_rd_router: one-cycle read tag pipeline steering memory read data to its requester.
module line_mem_rd_router
    import line_mem_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = bram_in_width
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  re,
    input  owner_t                owner,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  core_rvld,
    output logic [DATA_WIDTH-1:0] core_rdata,
    output logic                  host_rvld,
    output logic [DATA_WIDTH-1:0] host_rdata
);
    logic   tag_vld;
    owner_t tag_own;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_vld <= 1'b0;
            tag_own <= OWN_CORE;
        end else begin
            tag_vld <= re;
            if (re) tag_own <= owner;
        end
    end

    assign core_rvld  = tag_vld && tag_own == OWN_CORE;
    assign host_rvld  = tag_vld && tag_own == OWN_HOST;
    assign core_rdata = core_rvld ? mem_rdata : '0;
    assign host_rdata = host_rvld ? mem_rdata : '0;
endmodule

// File: rtl/line_mem_arbiter.sv
// line_mem_arbiter: shares the single-port linear memory between the core load/store path
// and the host preload engine; core has priority, host bursts are bounded and starvation-protected.
module line_mem_arbiter
    import line_mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH     = log2_bram_depth_in,
    parameter int DATA_WIDTH     = bram_in_width,
    parameter int HOST_BURST_MAX = 16,
    parameter int STARVE_LIMIT   = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_core_req,
    input  logic                  i_core_we,
    input  logic [ADDR_WIDTH-1:0] i_core_addr,
    input  logic [DATA_WIDTH-1:0] i_core_wdata,
    output logic                  o_core_gnt,
    output logic                  o_core_stall,
    output logic [DATA_WIDTH-1:0] o_core_rdata,
    output logic                  o_core_rvld,
    input  logic                  i_host_req,
    input  logic                  i_host_we,
    input  logic                  i_host_last,
    input  logic [ADDR_WIDTH-1:0] i_host_addr,
    input  logic [DATA_WIDTH-1:0] i_host_wdata,
    output logic                  o_host_gnt,
    output logic [DATA_WIDTH-1:0] o_host_rdata,
    output logic                  o_host_rvld,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic                  o_mem_re,
    output logic                  o_mem_we,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata,
    output logic                  o_host_busy
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int BW = $clog2(HOST_BURST_MAX + 1);

    state_t         state;
    logic [BW-1:0]  beat_cnt;
    logic [SW-1:0]  starve_cnt;
    logic           yield;
    logic           any_gnt;
    logic           sel_we;

    // Inside a burst the host owns the port outright; in idle it needs the core absent or to be starved.
    always_comb begin
        o_host_gnt = state == S_HBURST ? i_host_req
                   : i_host_req && (!i_core_req || starve_cnt == SW'(STARVE_LIMIT)) && !yield;
        o_core_gnt = state == S_IDLE && i_core_req && !o_host_gnt;
    end

    assign o_core_stall = i_core_req && !o_core_gnt;
    assign any_gnt      = o_host_gnt || o_core_gnt;
    assign sel_we       = o_host_gnt ? i_host_we : i_core_we;
    assign o_mem_re     = any_gnt && !sel_we;
    assign o_mem_we     = any_gnt && sel_we;
    assign o_mem_addr   = o_host_gnt ? i_host_addr : o_core_gnt ? i_core_addr : '0;
    assign o_mem_wdata  = o_host_gnt ? i_host_wdata : o_core_gnt ? i_core_wdata : '0;
    assign o_host_busy  = state == S_HBURST;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= S_IDLE;
            beat_cnt   <= '0;
            starve_cnt <= '0;
            yield      <= 1'b0;
        end else begin
            starve_cnt <= o_host_gnt ? '0
                        : (i_host_req && starve_cnt != SW'(STARVE_LIMIT)) ? starve_cnt + 1'b1 : starve_cnt;
            if (state == S_IDLE) begin
                yield <= 1'b0;
                if (o_host_gnt && !i_host_last && HOST_BURST_MAX > 1) begin
                    state    <= S_HBURST;
                    beat_cnt <= BW'(1);
                end
            end else if (!i_host_req) begin
                state <= S_IDLE;
            end else begin
                beat_cnt <= beat_cnt + 1'b1;
                // A final beat ends the burst cleanly; hitting the cap forces one idle cycle for the core.
                if (i_host_last || beat_cnt == BW'(HOST_BURST_MAX - 1)) begin
                    state <= S_IDLE;
                    yield <= !i_host_last;
                end
            end
        end
    end

    line_mem_rd_router #(.DATA_WIDTH(DATA_WIDTH)) u_rd_router (
        .clk        (i_clk),
        .rst        (i_rst),
        .re         (o_mem_re),
        .owner      (o_host_gnt ? OWN_HOST : OWN_CORE),
        .mem_rdata  (i_mem_rdata),
        .core_rvld  (o_core_rvld),
        .core_rdata (o_core_rdata),
        .host_rvld  (o_host_rvld),
        .host_rdata (o_host_rdata)
    );
endmodule

// File: tb/tb_line_mem_arbiter.sv
// tb_line_mem_arbiter: directed and randomized checks of the arbiter against a transaction-level model.
module tb_line_mem_arbiter;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int HB = 16;
    localparam int SL = 8;
    localparam int OW = 114;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_core_req = 1'b0, i_core_we = 1'b0;
    logic [AW-1:0] i_core_addr = '0;
    logic [DW-1:0] i_core_wdata = '0;
    logic          i_host_req = 1'b0, i_host_we = 1'b0, i_host_last = 1'b0;
    logic [AW-1:0] i_host_addr = '0;
    logic [DW-1:0] i_host_wdata = '0;
    logic          o_core_gnt, o_core_stall, o_core_rvld, o_host_gnt, o_host_rvld;
    logic          o_mem_re, o_mem_we, o_host_busy;
    logic [DW-1:0] o_core_rdata, o_host_rdata, o_mem_wdata, i_mem_rdata;
    logic [AW-1:0] o_mem_addr;

    int checks = 0;
    int errors = 0;

    always #5 i_clk = ~i_clk;

    line_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .HOST_BURST_MAX(HB), .STARVE_LIMIT(SL)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_core_req(i_core_req), .i_core_we(i_core_we), .i_core_addr(i_core_addr), .i_core_wdata(i_core_wdata),
        .o_core_gnt(o_core_gnt), .o_core_stall(o_core_stall), .o_core_rdata(o_core_rdata), .o_core_rvld(o_core_rvld),
        .i_host_req(i_host_req), .i_host_we(i_host_we), .i_host_last(i_host_last), .i_host_addr(i_host_addr),
        .i_host_wdata(i_host_wdata), .o_host_gnt(o_host_gnt), .o_host_rdata(o_host_rdata), .o_host_rvld(o_host_rvld),
        .o_mem_addr(o_mem_addr), .o_mem_re(o_mem_re), .o_mem_we(o_mem_we), .o_mem_wdata(o_mem_wdata),
        .i_mem_rdata(i_mem_rdata), .o_host_busy(o_host_busy)
    );

    // Stand-in for LineMemory: registered read, one cycle latency.
    logic [DW-1:0] env_mem [0:1023];
    always @(posedge i_clk) begin
        if (o_mem_we) env_mem[o_mem_addr] <= o_mem_wdata;
        if (o_mem_re) i_mem_rdata <= env_mem[o_mem_addr];
    end

    // Reference model: who owns the port, how many beats the host has had, pending read.
    bit            m_burst, m_yield, m_rd_v, m_rd_h;
    int            m_beats, m_starve;
    logic [DW-1:0] m_rd_d;
    logic [DW-1:0] ref_mem [0:1023];
    logic          e_hg, e_cg, e_wr;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    logic [OW-1:0] exp_all;
    wire  [OW-1:0] obs_all = {o_core_gnt, o_core_stall, o_core_rdata, o_core_rvld, o_host_gnt, o_host_rdata,
                              o_host_rvld, o_mem_addr, o_mem_re, o_mem_we, o_mem_wdata, o_host_busy};

    always_comb begin
        e_hg = m_burst ? i_host_req : (i_host_req && !m_yield && (!i_core_req || m_starve == SL));
        e_cg = !m_burst && i_core_req && !e_hg;
        e_wr = e_hg ? i_host_we : i_core_we;
        e_addr = e_hg ? i_host_addr : (e_cg ? i_core_addr : '0);
        e_wd = e_hg ? i_host_wdata : (e_cg ? i_core_wdata : '0);
        exp_all = {e_cg, i_core_req && !e_cg, (m_rd_v && !m_rd_h) ? m_rd_d : 32'h0, m_rd_v && !m_rd_h,
                   e_hg, (m_rd_v && m_rd_h) ? m_rd_d : 32'h0, m_rd_v && m_rd_h, e_addr,
                   (e_hg || e_cg) && !e_wr, (e_hg || e_cg) && e_wr, e_wd, m_burst};
    end

    always @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            m_burst = 0; m_yield = 0; m_rd_v = 0; m_beats = 0; m_starve = 0;
        end else begin
            m_rd_v = (e_hg || e_cg) && !e_wr;
            m_rd_h = e_hg;
            if (m_rd_v) m_rd_d = ref_mem[e_addr];
            if ((e_hg || e_cg) && e_wr) ref_mem[e_addr] = e_wd;
            m_starve = e_hg ? 0 : (i_host_req ? (m_starve < SL ? m_starve + 1 : SL) : m_starve);
            if (!m_burst) begin
                m_yield = 0;
                if (e_hg && !i_host_last) begin m_burst = 1; m_beats = 1; end
            end else if (!i_host_req) begin
                m_burst = 0;
            end else begin
                m_beats++;
                if (i_host_last) m_burst = 0;
                else if (m_beats == HB) begin m_burst = 0; m_yield = 1; end
            end
        end
    end

    task automatic set_in(input logic cr, input logic cw, input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                          input logic hr, input logic hw, input logic hl, input logic [AW-1:0] ha,
                          input logic [DW-1:0] hd);
        @(negedge i_clk);
        i_core_req = cr; i_core_we = cw; i_core_addr = ca; i_core_wdata = cd;
        i_host_req = hr; i_host_we = hw; i_host_last = hl; i_host_addr = ha; i_host_wdata = hd;
        #1;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (obs_all !== '0) begin errors++; $display("FAIL reset_outputs: got %h want 0", obs_all); end
        @(negedge i_clk);
        i_rst = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (obs_all !== exp_all || o_host_busy !== 1'b0) begin
            errors++; $display("FAIL reset_release: got %h want %h", obs_all, exp_all);
        end
    endtask

    task automatic test_core_only();
        set_in(0, 0, 0, 0, 1, 1, 1, 10'd5, 32'hDEADBEEF);
        checks++;
        if (o_host_gnt !== 1'b1 || o_mem_we !== 1'b1) begin
            errors++; $display("FAIL preload_gnt: got gnt=%b we=%b want 1 1", o_host_gnt, o_mem_we);
        end
        set_in(1, 0, 10'd5, 0, 0, 0, 0, 0, 0);
        checks++;
        if (o_core_gnt !== 1'b1 || o_mem_re !== 1'b1 || o_mem_addr !== 10'd5 || obs_all !== exp_all) begin
            errors++; $display("FAIL core_load_gnt: got gnt=%b re=%b addr=%0d want 1 1 5", o_core_gnt, o_mem_re, o_mem_addr);
        end
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (o_core_rvld !== 1'b1 || o_core_rdata !== 32'hDEADBEEF || o_host_rvld !== 1'b0 || o_host_rdata !== '0) begin
            errors++; $display("FAIL core_load_data: got rvld=%b data=%h hrvld=%b want 1 deadbeef 0", o_core_rvld, o_core_rdata, o_host_rvld);
        end
    endtask

    task automatic test_contention();
        for (int i = 0; i < 20; i++) begin
            set_in(1, 0, AW'(i), 0, 1, 0, 1, 10'd7, 0);
            checks++;
            if (o_host_gnt !== (i % 9 == 8) || o_core_stall !== (i % 9 == 8) || obs_all !== exp_all) begin
                errors++; $display("FAIL contention cyc %0d: got hgnt=%b stall=%b want %b", i, o_host_gnt, o_core_stall, i % 9 == 8);
            end
        end
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_burst();
        for (int b = 0; b < 4; b++) begin
            set_in(b >= 1, 0, 0, 0, 1, 1, b == 3, AW'(b), DW'(32'h10 + b));
            checks++;
            if (o_host_gnt !== 1'b1 || o_core_stall !== (b >= 1) || obs_all !== exp_all) begin
                errors++; $display("FAIL burst beat %0d: got hgnt=%b stall=%b want 1 %b", b, o_host_gnt, o_core_stall, b >= 1);
            end
        end
        for (int b = 0; b < 5; b++) begin
            set_in(b < 4, 0, AW'(b), 0, 0, 0, 0, 0, 0);
            checks++;
            if ((b < 4 && o_core_gnt !== 1'b1) || (b > 0 && (o_core_rvld !== 1'b1 || o_core_rdata !== DW'(32'h10 + b - 1)))
                || obs_all !== exp_all) begin
                errors++; $display("FAIL burst_readback %0d: got gnt=%b rvld=%b data=%h want data %h", b, o_core_gnt, o_core_rvld, o_core_rdata, 32'h10 + b - 1);
            end
        end
    endtask

    task automatic test_forced_yield();
        int  k = 0;
        int  core_at = -1;
        bit  core_done = 0;
        for (int cyc = 0; cyc < 40 && k < 20; cyc++) begin
            set_in(cyc >= 1 && !core_done, 0, 0, 0, 1, 1, k == 19, AW'(k), DW'(32'h100 + k));
            checks++;
            if (o_host_gnt !== (cyc != 16) || obs_all !== exp_all) begin
                errors++; $display("FAIL yield cyc %0d: got hgnt=%b cgnt=%b want hgnt %b", cyc, o_host_gnt, o_core_gnt, cyc != 16);
            end
            if (o_host_gnt) k++;
            if (o_core_gnt) begin core_done = 1; core_at = cyc; end
        end
        checks++;
        if (core_at !== 16 || k !== 20) begin
            errors++; $display("FAIL yield_core_slot: got core at %0d beats %0d want 16 20", core_at, k);
        end
    endtask

    task automatic test_alternating();
        set_in(1, 0, 10'd1, 0, 0, 0, 0, 0, 0);
        set_in(0, 0, 0, 0, 1, 0, 1, 10'd2, 0);
        checks++;
        if (o_core_rvld !== 1'b1 || o_core_rdata !== 32'h101 || o_host_rvld !== 1'b0 || obs_all !== exp_all) begin
            errors++; $display("FAIL alt_c1: got rvld=%b data=%h want 1 101", o_core_rvld, o_core_rdata);
        end
        set_in(1, 0, 10'd3, 0, 0, 0, 0, 0, 0);
        checks++;
        if (o_host_rvld !== 1'b1 || o_host_rdata !== 32'h102 || o_core_rvld !== 1'b0 || obs_all !== exp_all) begin
            errors++; $display("FAIL alt_h2: got rvld=%b data=%h want 1 102", o_host_rvld, o_host_rdata);
        end
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (o_core_rvld !== 1'b1 || o_core_rdata !== 32'h103 || o_host_rvld !== 1'b0 || obs_all !== exp_all) begin
            errors++; $display("FAIL alt_c3: got rvld=%b data=%h want 1 103", o_core_rvld, o_core_rdata);
        end
    endtask

    task automatic test_reset_mid_read();
        set_in(0, 0, 0, 0, 1, 0, 1, 10'd2, 0);
        checks++;
        if (o_host_gnt !== 1'b1 || o_mem_re !== 1'b1) begin
            errors++; $display("FAIL midread_gnt: got gnt=%b re=%b want 1 1", o_host_gnt, o_mem_re);
        end
        @(posedge i_clk);
        i_rst = 1'b1;
        i_host_req = 1'b0; i_host_last = 1'b0; i_host_addr = '0;
        #1;
        checks++;
        if (obs_all !== '0) begin errors++; $display("FAIL midread_reset: got %h want 0", obs_all); end
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
            checks++;
            if (o_host_rvld !== 1'b0 || o_host_busy !== 1'b0 || obs_all !== '0) begin
                errors++; $display("FAIL midread_after %0d: got rvld=%b busy=%b outs=%h want 0", i, o_host_rvld, o_host_busy, obs_all);
            end
        end
    endtask

    task automatic test_random();
        int a = 0;
        for (int cyc = 0; cyc < 200 && a < 32; cyc++) begin
            set_in(0, 0, 0, 0, 1, 1, a % 8 == 7, AW'(a), $urandom);
            checks++;
            if (obs_all !== exp_all) begin errors++; $display("FAIL preload cyc %0d: got %h want %h", cyc, obs_all, exp_all); end
            if (o_host_gnt) a++;
        end
        for (int cyc = 0; cyc < 400; cyc++) begin
            set_in($urandom_range(0, 1), $urandom_range(0, 1), AW'($urandom_range(0, 31)), $urandom,
                   $urandom_range(0, 9) < 6, $urandom_range(0, 1), $urandom_range(0, 3) == 0,
                   AW'($urandom_range(0, 31)), $urandom);
            checks++;
            if (obs_all !== exp_all || (o_core_gnt && o_host_gnt)) begin
                errors++; $display("FAIL random cyc %0d: got %h want %h", cyc, obs_all, exp_all);
            end
        end
    endtask

    initial begin
        test_reset();
        test_core_only();
        test_contention();
        test_burst();
        test_forced_yield();
        test_alternating();
        test_reset_mid_read();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
